slicer_cfg_seq: RTL and testbench

AXI4-Lite master sequencer that programs the slicer IP's S00_AXI register bank from a parallel configuration vector and verifies it. On a start pulse it writes each register at consecutive word addresses, then reads every register back and compares it with the written value. It reports completion and any error to the surrounding control logic. It sits between system control and the slicer's AXI4-Lite slave port, replacing manual register programming.

---
 rtl/slicer_cfg_pkg.sv | 33 +++
 rtl/slicer_cfg_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_slicer_cfg_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slicer_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slicer_cfg_pkg
//  Description : Shared types and constants for the slicer configuration
//                sequencer (FSM states, error codes, AXI response codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package slicer_cfg_pkg;

   // Sequencer states: write every register, then read every register back.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_FINISH  = 3'd5
   } state_e;

   // Error classification reported alongside done.
   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE     = 2'd0;
   localparam err_code_t ERR_BRESP    = 2'd1;
   localparam err_code_t ERR_RRESP    = 2'd2;
   localparam err_code_t ERR_MISMATCH = 2'd3;

   // AXI response encodings.
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/slicer_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : slicer_cfg_seq
//  Description : AXI4-Lite master that writes a configuration vector into
//                consecutive slicer registers, reads each one back, and
//                reports completion plus the first error encountered.
//  Revision    : 1.0 - initial release
// ============================================================================
module slicer_cfg_seq
   import slicer_cfg_pkg::*;
#(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter int                            C_NUM_REGS         = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
   input  logic                                     ACLK,
   input  logic                                     ARESETN,
   // Control side
   input  logic                                     start,
   input  logic [C_NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     error,
   output logic [1:0]                               err_code,
   output logic [3:0]                               err_index,
   // Write address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
   output logic [2:0]                               M_AXI_AWPROT,
   output logic                                     M_AXI_AWVALID,
   input  logic                                     M_AXI_AWREADY,
   // Write data channel
   output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
   output logic                                     M_AXI_WVALID,
   input  logic                                     M_AXI_WREADY,
   // Write response channel
   input  logic [1:0]                               M_AXI_BRESP,
   input  logic                                     M_AXI_BVALID,
   output logic                                     M_AXI_BREADY,
   // Read address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
   output logic [2:0]                               M_AXI_ARPROT,
   output logic                                     M_AXI_ARVALID,
   input  logic                                     M_AXI_ARREADY,
   // Read data channel
   input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
   input  logic [1:0]                               M_AXI_RRESP,
   input  logic                                     M_AXI_RVALID,
   output logic                                     M_AXI_RREADY
);

   localparam int         c_aw       = C_M_AXI_ADDR_WIDTH;
   localparam int         c_dw       = C_M_AXI_DATA_WIDTH;
   localparam logic [3:0] c_last_idx = 4'(C_NUM_REGS - 1);

   state_e            state_q;
   logic [3:0]        idx_q;
   logic [3:0]        idx_d;
   logic              w_last;
   logic [c_dw-1:0]   regs_q [16];
   logic [c_dw-1:0]   w_cfg_word [16];

   logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [c_aw-1:0]   awaddr_q, araddr_q;
   logic [c_dw-1:0]   wdata_q;
   logic              busy_q, done_q, error_q;
   err_code_t         err_code_q;
   logic [3:0]        err_index_q;

   // Byte address of register slot i.
   function automatic logic [c_aw-1:0] reg_addr(input logic [3:0] i);
      reg_addr = C_BASE_ADDR + {{(c_aw-6){1'b0}}, i, 2'b00};
   endfunction

   // Fan the flat configuration vector out into a fixed 16-entry table so the
   // 4-bit index always addresses a legal slot; unused slots read as zero.
   for (genvar gi = 0; gi < 16; gi++) begin : g_cfg_word
      if (gi < C_NUM_REGS) begin : g_used
         assign w_cfg_word[gi] = cfg_data[c_dw*gi +: c_dw];
      end else begin : g_unused
         assign w_cfg_word[gi] = '0;
      end
   end

   assign w_last = (idx_q == c_last_idx);
   assign idx_d  = w_last ? 4'd0 : idx_q + 4'd1;

   // Sequencer: issues one write (AW+W) or one read at a time, advances on the
   // response handshake, and stops at the first bad response or mismatch.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= ST_IDLE;
         idx_q       <= 4'd0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_index_q <= 4'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < 16; i++) regs_q[i] <= w_cfg_word[i];
                  idx_q       <= 4'd0;
                  error_q     <= 1'b0;
                  err_code_q  <= ERR_NONE;
                  err_index_q <= 4'd0;
                  busy_q      <= 1'b1;
                  awvalid_q   <= 1'b1;
                  wvalid_q    <= 1'b1;
                  awaddr_q    <= reg_addr(4'd0);
                  wdata_q     <= w_cfg_word[0];
                  state_q     <= ST_WR_REQ;
               end
            end

            ST_WR_REQ: begin
               // AW and W complete independently; leave once both are done.
               if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
               if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
               if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end
            end

            ST_WR_RESP: begin
               if (M_AXI_BVALID) begin
                  bready_q <= 1'b0;
                  if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                     err_code_q  <= ERR_BRESP;
                     err_index_q <= idx_q;
                     error_q     <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= ST_FINISH;
                  end else if (w_last) begin
                     idx_q     <= 4'd0;
                     arvalid_q <= 1'b1;
                     araddr_q  <= reg_addr(4'd0);
                     state_q   <= ST_RD_REQ;
                  end else begin
                     idx_q     <= idx_d;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     awaddr_q  <= reg_addr(idx_d);
                     wdata_q   <= regs_q[idx_d];
                     state_q   <= ST_WR_REQ;
                  end
               end
            end

            ST_RD_REQ: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD_RESP;
               end
            end

            ST_RD_RESP: begin
               if (M_AXI_RVALID) begin
                  rready_q <= 1'b0;
                  if (M_AXI_RRESP != AXI_RESP_OKAY) begin
                     err_code_q  <= ERR_RRESP;
                     err_index_q <= idx_q;
                     error_q     <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= ST_FINISH;
                  end else if (M_AXI_RDATA != regs_q[idx_q]) begin
                     err_code_q  <= ERR_MISMATCH;
                     err_index_q <= idx_q;
                     error_q     <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= ST_FINISH;
                  end else if (w_last) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     idx_q     <= idx_d;
                     arvalid_q <= 1'b1;
                     araddr_q  <= reg_addr(idx_d);
                     state_q   <= ST_RD_REQ;
                  end
               end
            end

            ST_FINISH: begin
               // done pulses during this cycle; busy drops with the return to idle.
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign err_index     = err_index_q;

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_slicer_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slicer_cfg_seq
//  Description : Bench for slicer_cfg_seq with a reactive AXI4-Lite slave and
//                a transaction-level expectation model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_slicer_cfg_seq;

   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h0;

   logic            ACLK    = 1'b0;
   logic            ARESETN = 1'b0;
   logic            start   = 1'b0;
   logic [N*32-1:0] cfg_data = '0;
   logic            busy, done, error;
   logic [1:0]      err_code;
   logic [3:0]      err_index;

   logic [31:0] AWADDR, ARADDR, WDATA;
   logic [31:0] RDATA = '0;
   logic [2:0]  AWPROT, ARPROT;
   logic [3:0]  WSTRB;
   logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
   logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
   logic        BVALID = 1'b0, RVALID = 1'b0;
   logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;

   always #5 ACLK = ~ACLK;

   slicer_cfg_seq #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_NUM_REGS        (N),
      .C_BASE_ADDR       (BASE)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error),
      .err_code(err_code), .err_index(err_index),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
      .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
      .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT),
      .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
      .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   // ---------------------------------------------------------------- scoring
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // ---------------------------------------------------------------- scenario knobs
   logic [31:0] cfg_words [N];
   int aw_delay  = 0;
   int bresp_bad = -1;
   int rd_bad    = -1;

   // ---------------------------------------------------------------- model
   // Expected transactions and outcome, derived from the register list and the
   // slave's planned fault.
   int          exp_nw, exp_nr, exp_idx;
   logic [1:0]  exp_code;
   logic [31:0] exp_addr [N];
   logic [31:0] exp_data [N];
   int          exp_done_cyc = -1;
   logic        exp_busy = 1'b0;

   task automatic model_build();
      for (int k = 0; k < N; k++) begin
         exp_addr[k] = BASE + 32'(4 * k);
         exp_data[k] = cfg_words[k];
      end
      if (bresp_bad >= 0) begin
         exp_nw = bresp_bad + 1; exp_nr = 0;          exp_code = 2'd1; exp_idx = bresp_bad;
      end else if (rd_bad >= 0) begin
         exp_nw = N;             exp_nr = rd_bad + 1; exp_code = 2'd3; exp_idx = rd_bad;
      end else begin
         exp_nw = N;             exp_nr = N;          exp_code = 2'd0; exp_idx = 0;
      end
   endtask

   // ---------------------------------------------------------------- slave
   // Decides READY/response values mid-cycle; a handshake seen here completes
   // on the following rising edge.
   logic [31:0] mem [16];
   int          aw_wait = 0;
   bit          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
   logic [31:0] aw_addr_l = '0, w_data_l = '0, ar_addr_l = '0;

   function automatic int reg_of(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return int'(off[3:0]);
   endfunction

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
         BRESP = 2'b00; RRESP = 2'b00; RDATA = '0;
         aw_wait = 0; aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      end else begin
         if (b_fire) begin BVALID = 0; b_fire = 0; end
         if (r_fire) begin RVALID = 0; r_fire = 0; end
         if (aw_got && w_got && !BVALID) begin
            mem[reg_of(aw_addr_l)] = w_data_l;
            BRESP  = (reg_of(aw_addr_l) == bresp_bad) ? 2'b10 : 2'b00;
            BVALID = 1; aw_got = 0; w_got = 0;
         end
         if (ar_got && !RVALID) begin
            RDATA  = (reg_of(ar_addr_l) == rd_bad) ? 32'hDEADBEEF : mem[reg_of(ar_addr_l)];
            RRESP  = 2'b00;
            RVALID = 1; ar_got = 0;
         end
         AWREADY = (aw_wait >= aw_delay);
         WREADY  = 1;
         ARREADY = 1;
         if (AWVALID && AWREADY) begin aw_got = 1; aw_addr_l = AWADDR; aw_wait = 0; end
         else if (AWVALID) aw_wait++;
         if (WVALID && WREADY)   begin w_got = 1;  w_data_l = WDATA; end
         if (ARVALID && ARREADY) begin ar_got = 1; ar_addr_l = ARADDR; end
         if (BVALID && BREADY) b_fire = 1;
         if (RVALID && RREADY) r_fire = 1;
      end
   end

   // ---------------------------------------------------------------- compare
   int aw_n, w_n, ar_n, b_n, r_n;
   int aw_first_cyc, w_first_cyc, done_cyc, start_cyc;
   bit done_seen = 0;

   always @(negedge ACLK) begin
      #1;
      if (ARESETN) begin
         check("prot_strb", {AWPROT, ARPROT, WSTRB}, {3'b000, 3'b000, 4'hF});
         check("busy", busy, exp_busy);
         check("ready_scope",
               {(!BREADY || (aw_n == w_n && aw_n == b_n + 1)), (!RREADY || (ar_n == r_n + 1))},
               2'b11);
         if (AWVALID && AWREADY) begin
            if (aw_n < exp_nw) check("aw_addr", AWADDR, exp_addr[aw_n]);
            else               check("aw_count", aw_n + 1, exp_nw);
            if (aw_n == 0) aw_first_cyc = cyc;
            aw_n++;
         end
         if (WVALID && WREADY) begin
            if (w_n < exp_nw) check("w_data", WDATA, exp_data[w_n]);
            else              check("w_count", w_n + 1, exp_nw);
            if (w_n == 0) w_first_cyc = cyc;
            w_n++;
         end
         if (ARVALID && ARREADY) begin
            if (ar_n < exp_nr) check("ar_addr", ARADDR, exp_addr[ar_n]);
            else               check("ar_count", ar_n + 1, exp_nr);
            ar_n++;
         end
         if (BVALID && BREADY) b_n++;
         if (RVALID && RREADY) r_n++;
         if (done) begin
            check("done_result", {error, err_code, err_index},
                  {(exp_code != 2'd0), exp_code, 4'(exp_idx)});
            check("txn_counts", {8'(aw_n), 8'(w_n), 8'(ar_n)},
                  {8'(exp_nw), 8'(exp_nw), 8'(exp_nr)});
            if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
            done_seen = 1;
            done_cyc  = cyc;
            exp_busy  = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic arm();
      model_build();
      aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
      aw_first_cyc = -1; w_first_cyc = -1; done_seen = 0; done_cyc = -1;
   endtask

   task automatic issue_start(input bit zero_wait);
      @(negedge ACLK);
      for (int i = 0; i < N; i++) cfg_data[32*i +: 32] = cfg_words[i];
      start        = 1'b1;
      start_cyc    = cyc;
      exp_done_cyc = zero_wait ? cyc + 4 * N + 1 : -1;
      @(negedge ACLK);
      start    = 1'b0;
      cfg_data = ~cfg_data;
      exp_busy = 1'b1;
      check("err_clear_on_start", {error, err_code, err_index}, 7'd0);
   endtask

   task automatic run(input bit zero_wait, input bit pokes);
      arm();
      issue_start(zero_wait);
      for (int k = 0; k < 400; k++) begin
         @(negedge ACLK);
         start = pokes && (k == 2 || k == 7);
         #2;
         if (done_seen) break;
      end
      start = 1'b0;
      if (!done_seen) begin
         n_cmp++; n_bad++;
         $display("FAIL run_timeout: done not seen, expected within 400 cycles");
      end
      @(negedge ACLK);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {AWVALID, WVALID, ARVALID, BREADY, RREADY, busy, done, error, err_code, err_index}, 14'd0);
      check({name, "_addr"}, {AWADDR, ARADDR}, 64'd0);
      check({name, "_wdata"}, WDATA, 32'd0);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      repeat (3) @(negedge ACLK);
      check_outputs_zero("reset_vals");
      ARESETN = 1'b1;

      // 1: zero-wait slave, registers 1..4
      cfg_words = '{32'd1, 32'd2, 32'd3, 32'd4};
      aw_delay = 0; bresp_bad = -1; rd_bad = -1;
      run(1'b1, 1'b0);
      check("t1_latency", done_cyc - start_cyc, 17);
      for (int i = 0; i < N; i++) check("t1_mem", mem[i], 64'(i + 1));

      // 2: AWREADY held off three cycles, WREADY immediate
      cfg_words = '{32'h1111_1111, 32'hA5A5_0001, 32'h0, 32'hFFFF_FFFF};
      aw_delay = 3;
      run(1'b0, 1'b0);
      check("t2_w_before_aw", (w_first_cyc >= 0) && (w_first_cyc < aw_first_cyc), 1'b1);
      check("t2_one_aw_per_reg", aw_n, 4);
      aw_delay = 0;

      // 3: SLVERR on register 2's write response
      cfg_words = '{32'd1, 32'd2, 32'd3, 32'd4};
      bresp_bad = 2;
      run(1'b0, 1'b0);
      check("t3_err", {error, err_code, err_index}, {1'b1, 2'd1, 4'd2});
      check("t3_no_read", ar_n, 0);
      bresp_bad = -1;

      // 4: register 3 reads back 0xDEADBEEF
      rd_bad = 3;
      run(1'b0, 1'b0);
      check("t4_err", {err_code, err_index}, {2'd3, 4'd3});
      repeat (3) @(negedge ACLK);
      check("t4_err_hold", {error, err_code, err_index}, {1'b1, 2'd3, 4'd3});
      rd_bad = -1;

      // 5: starts while busy are ignored; a new start clears the held error
      cfg_words = '{32'd9, 32'd8, 32'd7, 32'd6};
      run(1'b1, 1'b1);
      check("t5_clean", {error, err_code}, 3'd0);

      // 6: asynchronous reset during the read phase, then a clean rerun
      cfg_words = '{32'd1, 32'd2, 32'd3, 32'd4};
      arm();
      issue_start(1'b0);
      begin
         bit seen;
         seen = 0;
         for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (ARVALID) begin seen = 1; break; end
         end
         check("t6_reached_rd_req", seen, 1'b1);
      end
      #3;
      ARESETN  = 1'b0;
      exp_busy = 1'b0;
      #1;
      check_outputs_zero("t6_async_reset");
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      run(1'b1, 1'b0);
      check("t6_rerun", {error, err_code}, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation did not finish, expected completion before 500us");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
